// File: rtl/exu_flush_pipe.sv
// rtl/exu_flush_pipe.sv - multi-channel issue-to-execute pipe with ROB-age flush
//
// CH independent elastic pipes, each DEPTH register stages deep, carrying a
// ROB index and a payload. A backend redirect clears, at the next edge, every
// entry (in any stage or on the input) that is not strictly older than
// redirect_idx. Bubbles collapse, so one entry per channel per cycle can flow.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset (clears valid bits only)
//   in_valid      per-channel issue valid
//   in_ready      per-channel accept (combinational, independent of in_valid)
//   in_rob        per-channel ROB index {wrap flag, index}
//   in_data       per-channel payload
//   redirect      flush request
//   redirect_idx  ROB index of the flushing instruction (itself killed)
//   out_valid     per-channel final-stage valid, masked by a live flush
//   out_ready     per-channel downstream accept
//   out_rob       final-stage ROB index
//   out_data      final-stage payload
//   out_oldest    one-hot of the oldest presenting channel (lowest wins ties)
//   occupancy     per-channel count of valid stages
module exu_flush_pipe #(
    parameter int CH    = 4,
    parameter int DEPTH = 2,
    parameter int DW    = 64,
    parameter int RW    = 6,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic [CH*RW-1:0]  in_rob,
    input  logic [CH*DW-1:0]  in_data,
    input  logic              redirect,
    input  logic [RW-1:0]     redirect_idx,
    output logic [CH-1:0]     out_valid,
    input  logic [CH-1:0]     out_ready,
    output logic [CH*RW-1:0]  out_rob,
    output logic [CH*DW-1:0]  out_data,
    output logic [CH-1:0]     out_oldest,
    output logic [CH*OW-1:0]  occupancy
);

    // Age order on ROB indices: the wrap flag flips the sense of the low-bit
    // compare, so the raw RW-bit magnitude is never used.
    function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic res;
        if (a[RW-1] == b[RW-1]) begin
            res = (a[RW-2:0] < b[RW-2:0]);
        end else begin
            res = (a[RW-2:0] > b[RW-2:0]);
        end
        return res;
    endfunction

    function automatic logic kill_of(input logic flush, input logic [RW-1:0] idx,
                                     input logic [RW-1:0] x);
        return flush & ~older(x, idx);
    endfunction

    // Stage 0 is the entry stage, stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0] st_valid [CH];
    logic [RW-1:0]    st_rob   [CH][DEPTH];
    logic [DW-1:0]    st_data  [CH][DEPTH];

    logic [DEPTH-1:0] st_kill  [CH];
    logic [DEPTH-1:0] st_move  [CH];
    logic [CH-1:0]    in_kill;
    logic [CH-1:0]    in_take;

    always_comb begin
        logic          open;
        logic [OW-1:0] cnt;
        open      = 1'b0;
        cnt       = '0;
        out_valid = '0;
        in_ready  = '0;
        in_kill   = '0;
        in_take   = '0;
        out_rob   = '0;
        out_data  = '0;
        occupancy = '0;
        for (int c = 0; c < CH; c++) begin
            st_kill[c] = '0;
            st_move[c] = '0;
        end

        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_kill[c][k] = kill_of(redirect, redirect_idx, st_rob[c][k]);
            end

            out_valid[c] = ~rst & st_valid[c][DEPTH-1] & ~st_kill[c][DEPTH-1];

            // A stage moves when it holds something and there is a hole at or
            // below any later stage, or the final stage is handing off. Raw
            // (pre-flush) valid bits are used, so a slot freed by the flush
            // only becomes usable from the next cycle on.
            open                 = out_valid[c] & out_ready[c];
            st_move[c][DEPTH-1]  = open;
            for (int k = DEPTH - 2; k >= 0; k--) begin
                open          = open | ~st_valid[c][k+1];
                st_move[c][k] = st_valid[c][k] & open;
            end

            in_ready[c] = ~rst & (~st_valid[c][0] | st_move[c][0]);
            in_take[c]  = in_valid[c] & in_ready[c];
            in_kill[c]  = kill_of(redirect, redirect_idx, in_rob[c*RW +: RW]);

            out_rob[c*RW +: RW]  = st_rob[c][DEPTH-1];
            out_data[c*DW +: DW] = st_data[c][DEPTH-1];

            cnt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                cnt = cnt + OW'(st_valid[c][k]);
            end
            occupancy[c*OW +: OW] = rst ? '0 : cnt;
        end
    end

    // Linear scan keeps the result one-hot even for ill-formed index sets;
    // a later channel only replaces the current pick when strictly older.
    always_comb begin
        logic          found;
        logic [RW-1:0] best_rob;
        found      = 1'b0;
        best_rob   = '0;
        out_oldest = '0;
        for (int c = 0; c < CH; c++) begin
            if (out_valid[c] && (!found || older(st_rob[c][DEPTH-1], best_rob))) begin
                found      = 1'b1;
                best_rob   = st_rob[c][DEPTH-1];
                out_oldest = '0;
                out_oldest[c] = 1'b1;
            end
        end
    end

    // Valid bits: the only reset state in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                st_valid[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 1; k < DEPTH; k++) begin
                    if (st_move[c][k-1]) begin
                        st_valid[c][k] <= ~st_kill[c][k-1];
                    end else if (st_move[c][k]) begin
                        st_valid[c][k] <= 1'b0;
                    end else begin
                        st_valid[c][k] <= st_valid[c][k] & ~st_kill[c][k];
                    end
                end
                // A killed input is still consumed; it simply lands invalid.
                if (in_take[c]) begin
                    st_valid[c][0] <= ~in_kill[c];
                end else if (st_move[c][0]) begin
                    st_valid[c][0] <= 1'b0;
                end else begin
                    st_valid[c][0] <= st_valid[c][0] & ~st_kill[c][0];
                end
            end
        end
    end

    // Payload and ROB registers: load-enabled, never reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (st_move[c][k-1]) begin
                    st_rob[c][k]  <= st_rob[c][k-1];
                    st_data[c][k] <= st_data[c][k-1];
                end
            end
            if (in_take[c]) begin
                st_rob[c][0]  <= in_rob[c*RW +: RW];
                st_data[c][0] <= in_data[c*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_exu_flush_pipe.sv
// tb/tb_exu_flush_pipe.sv - scoreboard bench for exu_flush_pipe
module tb_exu_flush_pipe;
    localparam int CH    = 4;
    localparam int DEPTH = 2;
    localparam int DW    = 64;
    localparam int RW    = 6;
    localparam int OW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    in_valid = '0;
    logic [CH-1:0]    in_ready;
    logic [CH*RW-1:0] in_rob = '0;
    logic [CH*DW-1:0] in_data = '0;
    logic             redirect = 1'b0;
    logic [RW-1:0]    redirect_idx = '0;
    logic [CH-1:0]    out_valid;
    logic [CH-1:0]    out_ready = '0;
    logic [CH*RW-1:0] out_rob;
    logic [CH*DW-1:0] out_data;
    logic [CH-1:0]    out_oldest;
    logic [CH*OW-1:0] occupancy;

    always #5 clk = ~clk;

    exu_flush_pipe #(.CH(CH), .DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rob(in_rob), .in_data(in_data),
        .redirect(redirect), .redirect_idx(redirect_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
        .out_data(out_data), .out_oldest(out_oldest), .occupancy(occupancy)
    );

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          exp_q   [CH][$];
    logic [RW-1:0] out_log [CH][$];
    int checks = 0;
    int errors = 0;

    function automatic bit older_m(input logic [RW-1:0] a, input logic [RW-1:0] b);
        int half = 1 << (RW - 1);
        int fa = int'(a) / half;
        int fb = int'(b) / half;
        int la = int'(a) % half;
        int lb = int'(b) % half;
        if (fa == fb) return la < lb;
        return la > lb;
    endfunction

    function automatic bit kill_m(input bit rd, input logic [RW-1:0] idx, input logic [RW-1:0] x);
        return rd && !older_m(x, idx);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs with the model queues, then applies this
    // cycle's hand-offs and flush to the model.
    always @(negedge clk) begin : monitor
        int            n;
        bit            fk;
        int            best;
        logic [RW-1:0] brob;
        logic [CH-1:0] exp_old;
        ent_t          fr;
        ent_t          tmp[$];
        if (rst) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_in_ready", 64'(in_ready), 64'(0));
            check("rst_occupancy", 64'(occupancy), 64'(0));
            check("rst_out_oldest", 64'(out_oldest), 64'(0));
            for (int c = 0; c < CH; c++) exp_q[c].delete();
        end else begin
            best = -1;
            brob = '0;
            exp_old = '0;
            for (int c = 0; c < CH; c++) begin
                if (out_valid[c] && exp_q[c].size() > 0) begin
                    if (best < 0 || older_m(exp_q[c][0].rob, brob)) begin
                        best = c;
                        brob = exp_q[c][0].rob;
                    end
                end
            end
            if (best >= 0) exp_old[best] = 1'b1;
            check("out_oldest", 64'(out_oldest), 64'(exp_old));
            for (int c = 0; c < CH; c++) begin
                n  = exp_q[c].size();
                fk = 1'b0;
                if (n > 0) fk = kill_m(redirect, redirect_idx, exp_q[c][0].rob);
                check($sformatf("occupancy[%0d]", c), 64'(occupancy[c*OW +: OW]), 64'(n));
                check($sformatf("in_ready[%0d]", c), 64'(in_ready[c]),
                      64'((n < DEPTH) || (!fk && out_ready[c])));
                if (n == DEPTH)
                    check($sformatf("full_out_valid[%0d]", c), 64'(out_valid[c]), 64'(!fk));
                if (out_valid[c]) begin
                    check($sformatf("out_valid_legal[%0d]", c), 64'(n > 0 && !fk), 64'(1));
                    if (n > 0) begin
                        fr = exp_q[c][0];
                        check($sformatf("out_rob[%0d]", c), 64'(out_rob[c*RW +: RW]), 64'(fr.rob));
                        check($sformatf("out_data[%0d]", c), out_data[c*DW +: DW], fr.data);
                        if (out_ready[c]) begin
                            out_log[c].push_back(fr.rob);
                            void'(exp_q[c].pop_front());
                        end
                    end
                end
                if (redirect) begin
                    tmp = {};
                    for (int i = 0; i < exp_q[c].size(); i++)
                        if (!kill_m(1'b1, redirect_idx, exp_q[c][i].rob)) tmp.push_back(exp_q[c][i]);
                    exp_q[c] = tmp;
                end
            end
        end
    end

    // Issue side: every accepted, unkilled input becomes an expected output.
    always @(negedge clk) begin : issue_rec
        ent_t e;
        #1;
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c] && in_ready[c] &&
                    !kill_m(redirect, redirect_idx, in_rob[c*RW +: RW])) begin
                    e.rob  = in_rob[c*RW +: RW];
                    e.data = in_data[c*DW +: DW];
                    exp_q[c].push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [RW-1:0] r, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        in_valid[c] = 1'b1;
        in_rob[c*RW +: RW] = r;
        in_data[c*DW +: DW] = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #2;
            done = in_ready[c];
            tick();
        end
        in_valid[c] = 1'b0;
        check($sformatf("send_accept ch%0d rob%0d", c, r), 64'(done), 64'(1));
    endtask

    task automatic drain(input int limit);
        bit empty;
        empty = 1'b0;
        out_ready = '1;
        for (int i = 0; i < limit && !empty; i++) begin
            @(negedge clk);
            #1;
            empty = 1'b1;
            for (int c = 0; c < CH; c++) if (exp_q[c].size() != 0) empty = 1'b0;
        end
        check("drain_empty", 64'(empty), 64'(1));
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [RW-1:0] next_rob;
        logic [CH-1:0] consumed;
        int            pct;
        int            rdy_tab [6] = '{100, 30, 70, 5, 90, 50};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(4'hF));
        tick();

        // Single entry, free-flowing output: latency DEPTH, occupancy 1,1,0.
        out_ready = '1;
        in_valid[0] = 1'b1;
        in_rob[0 +: RW] = 6'd5;
        in_data[0 +: DW] = 64'hA1;
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("lat_occ_c1", 64'(occupancy[0 +: OW]), 64'(1));
        check("lat_ov_c1", 64'(out_valid[0]), 64'(0));
        @(negedge clk);
        check("lat_occ_c2", 64'(occupancy[0 +: OW]), 64'(1));
        check("lat_ov_c2", 64'(out_valid[0]), 64'(1));
        check("lat_data_c2", out_data[0 +: DW], 64'hA1);
        @(negedge clk);
        check("lat_occ_c3", 64'(occupancy[0 +: OW]), 64'(0));
        check("lat_ov_c3", 64'(out_valid[0]), 64'(0));
        tick();

        // Backpressure on ch1: two fill the pipe, third waits, order kept.
        out_log[1].delete();
        out_ready[1] = 1'b0;
        send(1, 6'd1, 64'h101);
        send(1, 6'd2, 64'h102);
        in_valid[1] = 1'b1;
        in_rob[RW +: RW] = 6'd3;
        in_data[DW +: DW] = 64'h103;
        @(negedge clk);
        #2;
        check("bp_occ", 64'(occupancy[OW +: OW]), 64'(2));
        check("bp_in_ready", 64'(in_ready[1]), 64'(0));
        check("bp_out_rob", 64'(out_rob[RW +: RW]), 64'(1));
        tick();
        @(negedge clk);
        #2;
        check("bp_hold_data", out_data[DW +: DW], 64'h101);
        tick();
        out_ready[1] = 1'b1;
        send(1, 6'd3, 64'h103);
        drain(20);
        check("bp_count", 64'(out_log[1].size()), 64'(3));
        for (int i = 0; i < out_log[1].size() && i < 3; i++)
            check($sformatf("bp_order%0d", i), 64'(out_log[1][i]), 64'(i + 1));

        // Redirect at 11 keeps 10, kills 12; redirect at 10 kills both.
        out_log[2].delete();
        out_ready[2] = 1'b0;
        send(2, 6'd10, 64'h210);
        send(2, 6'd12, 64'h212);
        redirect = 1'b1;
        redirect_idx = 6'd11;
        @(negedge clk);
        #2;
        check("rd11_ov", 64'(out_valid[2]), 64'(1));
        tick();
        redirect = 1'b0;
        @(negedge clk);
        #2;
        check("rd11_occ", 64'(occupancy[2*OW +: OW]), 64'(1));
        check("rd11_rob", 64'(out_rob[2*RW +: RW]), 64'(10));
        tick();
        drain(20);
        check("rd11_emit_cnt", 64'(out_log[2].size()), 64'(1));
        if (out_log[2].size() > 0) check("rd11_emit_rob", 64'(out_log[2][0]), 64'(10));
        out_ready[2] = 1'b0;
        send(2, 6'd10, 64'h310);
        send(2, 6'd12, 64'h312);
        redirect = 1'b1;
        redirect_idx = 6'd10;
        @(negedge clk);
        #2;
        check("rd10_ov", 64'(out_valid[2]), 64'(0));
        tick();
        redirect = 1'b0;
        @(negedge clk);
        #2;
        check("rd10_occ", 64'(occupancy[2*OW +: OW]), 64'(0));
        tick();
        drain(20);
        check("rd10_emit_cnt", 64'(out_log[2].size()), 64'(1));

        // Wrap: {1,2} on ch0 vs {0,30} on ch3, ch3 is older.
        out_ready[0] = 1'b0;
        out_ready[3] = 1'b0;
        send(0, 6'd34, 64'h034);
        send(3, 6'd30, 64'h330);
        tick();
        @(negedge clk);
        #2;
        check("wrap_ov", 64'(out_valid), 64'(4'b1001));
        check("wrap_oldest", 64'(out_oldest), 64'(4'b1000));
        tick();
        redirect = 1'b1;
        redirect_idx = 6'd32;
        @(negedge clk);
        #2;
        check("wrap_rd_ov", 64'(out_valid), 64'(4'b1000));
        check("wrap_rd_oldest", 64'(out_oldest), 64'(4'b1000));
        tick();
        redirect = 1'b0;
        @(negedge clk);
        #2;
        check("wrap_occ0", 64'(occupancy[0 +: OW]), 64'(0));
        check("wrap_occ3", 64'(occupancy[3*OW +: OW]), 64'(1));
        tick();
        drain(20);

        // Input younger than a same-cycle redirect is consumed and dropped.
        redirect = 1'b1;
        redirect_idx = 6'd20;
        in_valid[1] = 1'b1;
        in_rob[RW +: RW] = 6'd25;
        in_data[DW +: DW] = 64'h125;
        @(negedge clk);
        #2;
        check("drop_in_ready", 64'(in_ready[1]), 64'(1));
        tick();
        redirect = 1'b0;
        in_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check($sformatf("drop_occ%0d", i), 64'(occupancy[OW +: OW]), 64'(0));
            check($sformatf("drop_ov%0d", i), 64'(out_valid[1]), 64'(0));
        end
        tick();

        // Reset with every stage full.
        out_ready = '0;
        for (int c = 0; c < CH; c++) begin
            send(c, RW'(40 + 2 * c), 64'(c * 16 + 1));
            send(c, RW'(41 + 2 * c), 64'(c * 16 + 2));
        end
        @(negedge clk);
        #2;
        check("full_occ", 64'(occupancy), 64'(8'hAA));
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_ov", 64'(out_valid), 64'(4'hF));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("after_rst_ov", 64'(out_valid), 64'(0));
        check("after_rst_occ", 64'(occupancy), 64'(0));
        check("after_rst_in_ready", 64'(in_ready), 64'(4'hF));
        tick();

        // Randomized traffic with flushes, wrap and a mid-run reset.
        next_rob = '0;
        consumed = '0;
        in_valid = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            pct = rdy_tab[(cyc / 250) % 6];
            rst = (cyc == 900);
            for (int c = 0; c < CH; c++) begin
                if (!in_valid[c] || consumed[c]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        in_valid[c] = 1'b1;
                        in_rob[c*RW +: RW] = next_rob;
                        in_data[c*DW +: DW] = {$urandom, $urandom};
                        next_rob = next_rob + 1'b1;
                    end else begin
                        in_valid[c] = 1'b0;
                    end
                end
                out_ready[c] = ($urandom_range(0, 99) < pct);
            end
            redirect = ($urandom_range(0, 99) < 7);
            redirect_idx = next_rob - RW'($urandom_range(1, 10));
            @(negedge clk);
            #2;
            consumed = in_valid & in_ready;
            tick();
        end
        rst = 1'b0;
        in_valid = '0;
        redirect = 1'b0;
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
